// File: rtl/div_seq_32_pkg.sv
// Shared definitions for the sequential restoring divider: state encodings,
// width constants and two's-complement helpers.
package div_seq_32_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        DIV_ST_IDLE   = 2'd0,
        DIV_ST_CALC   = 2'd1,
        DIV_ST_FIXUP  = 2'd2,
        DIV_ST_FINISH = 2'd3
    } div_state_e;

    function automatic logic [DATA_WIDTH-1:0] twos_neg(input logic [DATA_WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    // 32'h80000000 maps to 2^31, which is still representable as unsigned.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? twos_neg(v) : v;
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtraction for one restoring-division step:
// shifted partial remainder minus zero-extended divisor.
module div_trial_sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   shifted_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   trial_o,
    output logic             neg_o
);

    assign trial_o = shifted_i - {1'b0, divisor_i};
    assign neg_o   = trial_o[WIDTH];

endmodule

// File: rtl/div_seq_32.sv
// Sequential 32-bit restoring divider, one quotient bit per clock, with
// signed/unsigned operands and a START/BUSY/DONE handshake.
module div_seq_32
    import div_seq_32_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_BY_ZERO
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_neg;

    assign shifted = {r_q, q_q[WIDTH-1]};

    div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
        .shifted_i (shifted),
        .divisor_i (d_q),
        .trial_o   (trial),
        .neg_o     (trial_neg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            DIV_ST_IDLE: begin
                if (START) begin
                    if (DIVISOR != '0) begin
                        q_d     = SIGNED ? magnitude(DIVIDEND) : DIVIDEND;
                        d_d     = SIGNED ? magnitude(DIVISOR) : DIVISOR;
                        neg_q_d = SIGNED & (DIVIDEND[WIDTH-1] ^ DIVISOR[WIDTH-1]);
                        neg_r_d = SIGNED & DIVIDEND[WIDTH-1];
                        r_d     = '0;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        dbz_d   = 1'b0;
                        state_d = DIV_ST_CALC;
                    end else begin
                        // Results are written now so they are valid alongside DONE.
                        q_d     = DIVIDEND;
                        quot_d  = DIV_ZERO_QUOTIENT;
                        rem_d   = DIVIDEND;
                        dbz_d   = 1'b1;
                        state_d = DIV_ST_FINISH;
                    end
                end
            end
            DIV_ST_CALC: begin
                r_d   = trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], ~trial_neg};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DIV_ST_FIXUP;
                end
            end
            DIV_ST_FIXUP: begin
                quot_d  = neg_q_q ? twos_neg(q_q) : q_q;
                rem_d   = neg_r_q ? twos_neg(r_q) : r_q;
                state_d = DIV_ST_FINISH;
            end
            DIV_ST_FINISH: begin
                state_d = DIV_ST_IDLE;
            end
            default: begin
                state_d = DIV_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= DIV_ST_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign QUOTIENT    = quot_q;
    assign REMAINDER   = rem_q;
    assign DIV_BY_ZERO = dbz_q;
    assign BUSY        = (state_q == DIV_ST_CALC) || (state_q == DIV_ST_FIXUP);
    assign DONE        = (state_q == DIV_ST_FINISH);

endmodule

// File: tb/tb_div_seq_32.sv
// Scoreboard bench for div_seq_32: directed cases plus randomized operands
// checked against an arithmetic reference model.
module tb_div_seq_32;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        sgn;
    logic [31:0] DIVIDEND;
    logic [31:0] DIVISOR;
    logic [31:0] QUOTIENT;
    logic [31:0] REMAINDER;
    logic        BUSY;
    logic        DONE;
    logic        DIV_BY_ZERO;

    div_seq_32 dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .SIGNED      (sgn),
        .DIVIDEND    (DIVIDEND),
        .DIVISOR     (DIVISOR),
        .QUOTIENT    (QUOTIENT),
        .REMAINDER   (REMAINDER),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .DIV_BY_ZERO (DIV_BY_ZERO)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int unsigned done_cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint sa, sb_l, qq, rr;
        e.done_cyc = 0;
        if (b == 32'd0) begin
            e.q = 32'hFFFFFFFF; e.r = a; e.dbz = 1'b1;
        end else if (s) begin
            sa   = longint'($signed(a));
            sb_l = longint'($signed(b));
            qq   = sa / sb_l;
            rr   = sa % sb_l;
            e.q  = qq[31:0]; e.r = rr[31:0]; e.dbz = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic dbz);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz; e.done_cyc = 0;
        return e;
    endfunction

    // Monitor: pops an expectation every time the DUT presents DONE.
    always @(negedge CLK) begin
        exp_t e;
        if (RST === 1'b0 && DONE === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; fails++;
                $display("FAIL done_unexpected: got DONE=1 expected no pending result (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("quotient",    QUOTIENT, e.q);
                chk("remainder",   REMAINDER, e.r);
                chk("div_by_zero", {31'b0, DIV_BY_ZERO}, {31'b0, e.dbz});
                chk("done_cycle",  cyc, e.done_cyc);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input exp_t e_in, input bit pulse);
        exp_t e;
        int   busy_cnt;
        int   n;
        e = e_in;
        @(negedge CLK);
        e.done_cyc = cyc + (e.dbz ? 1 : 34);
        sb.push_back(e);
        START = 1'b1; DIVIDEND = a; DIVISOR = b; sgn = s;
        @(negedge CLK);
        busy_cnt = 0;
        n = 0;
        while (DONE !== 1'b1 && n < 60) begin
            if (BUSY === 1'b1) busy_cnt++;
            START = (pulse && n == 3);
            if (pulse && n == 3) begin
                DIVIDEND = 32'd9; DIVISOR = 32'd3; sgn = 1'b0;
            end else begin
                DIVIDEND = $urandom; DIVISOR = $urandom; sgn = 1'($urandom);
            end
            @(negedge CLK);
            n++;
        end
        START = 1'b0;
        if (n >= 60) begin
            checks++; fails++;
            $display("FAIL done_timeout: got no DONE after %0d cycles expected DONE", n);
        end
        chk("busy_cycles",  32'(busy_cnt), e.dbz ? 32'd0 : 32'd33);
        chk("busy_at_done", {31'b0, BUSY}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        RST = 1'b1; START = 1'b0; sgn = 1'b0; DIVIDEND = '0; DIVISOR = '0;
        #12;
        chk("rst_quotient",  QUOTIENT, 32'd0);
        chk("rst_remainder", REMAINDER, 32'd0);
        chk("rst_busy",      {31'b0, BUSY}, 32'd0);
        chk("rst_done",      {31'b0, DONE}, 32'd0);
        chk("rst_dbz",       {31'b0, DIV_BY_ZERO}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        issue(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0), 1'b0);
        issue(32'hFFFFFFF9, 32'd2, 1'b1, mk(32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0), 1'b0);
        issue(32'hFFFFFFF9, 32'd2, 1'b0, mk(32'h7FFFFFFC, 32'h1, 1'b0), 1'b0);
        issue(32'd5, 32'd0, 1'b0, mk(32'hFFFFFFFF, 32'd5, 1'b1), 1'b0);
        issue(32'd5, 32'd0, 1'b1, mk(32'hFFFFFFFF, 32'd5, 1'b1), 1'b0);
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, mk(32'h80000000, 32'd0, 1'b0), 1'b0);
        issue(32'hFFFFFFFF, 32'd1, 1'b0, mk(32'hFFFFFFFF, 32'd0, 1'b0), 1'b0);
        issue(32'd1000, 32'd10, 1'b0, mk(32'd100, 32'd0, 1'b0), 1'b1);

        // Asynchronous reset in the middle of a division.
        @(negedge CLK);
        sb.push_back(mk(32'd100, 32'd0, 1'b0));
        START = 1'b1; DIVIDEND = 32'd1000; DIVISOR = 32'd10; sgn = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst_quotient",  QUOTIENT, 32'd0);
        chk("arst_remainder", REMAINDER, 32'd0);
        chk("arst_busy",      {31'b0, BUSY}, 32'd0);
        chk("arst_done",      {31'b0, DONE}, 32'd0);
        chk("arst_dbz",       {31'b0, DIV_BY_ZERO}, 32'd0);
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        issue(32'd9, 32'd3, 1'b0, mk(32'd3, 32'd0, 1'b0), 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = s ? 32'hFFFFFFFF - 32'($urandom_range(0, 15)) : b;
                3: a = 32'h80000000;
                4: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            issue(a, b, s, model(a, b, s), 1'b0);
        end

        @(negedge CLK);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/div_seq_32.md
Name: div_seq_32

Overview:
- Sequential 32-bit restoring divider for the ALU datapath. It is the inverse-operation companion of the combinational 32-bit ripple add/sub unit.
- Produces one quotient bit per clock from one 33-bit trial subtraction per cycle.
- Supports signed and unsigned operands.
- Uses a START/BUSY/DONE handshake so the control unit can stall on division.

Parameters:
- WIDTH, 32, operand/result width; must match `DATA_WIDTH.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- CLK  input  1  system clock, rising-edge active
- RST  input  1  reset, asynchronous, active-high
- START  input  1  request; sampled only in IDLE
- SIGNED  input  1  1 = two's-complement divide, 0 = unsigned; sampled with START
- DIVIDEND  input  32  numerator; sampled with START
- DIVISOR  input  32  denominator; sampled with START
- QUOTIENT  output  32  result quotient, registered
- REMAINDER  output  32  result remainder, registered
- BUSY  output  1  high from the cycle after START until DONE
- DONE  output  1  one-cycle pulse when QUOTIENT/REMAINDER become valid
- DIV_BY_ZERO  output  1  registered flag, valid with DONE, held until next START

Behaviour:
- Reset: RST=1 forces the following, regardless of CLK and at any point mid-operation, with no partial result retained:
  - state IDLE, counter 0
  - QUOTIENT, REMAINDER, and internal R/Q/D registers = 0
  - BUSY=0, DONE=0, DIV_BY_ZERO=0
- States (encodings in shared package): IDLE, CALC, FIXUP, FINISH.
- IDLE:
  - START=1 and DIVISOR!=0:
    - latch magnitudes: |DIVIDEND| into Q, |DIVISOR| into D when SIGNED=1, raw values otherwise
    - latch neg_q = SIGNED & (DIVIDEND[31]^DIVISOR[31]) and neg_r = SIGNED & DIVIDEND[31]
    - R=0, counter=31, clear DIV_BY_ZERO, go to CALC
  - START=1 and DIVISOR=0: latch DIVIDEND, set DIV_BY_ZERO=1, go to FINISH.
  - Otherwise stay in IDLE; outputs hold their last values.
- CALC, once per cycle:
  - shifted = {R[31:0], Q[31]}; trial = shifted − {1'b0, D} (33-bit)
  - trial[32]=0: R=trial, Q={Q[30:0],1}
  - trial[32]=1: R=shifted, Q={Q[30:0],0}
  - counter decrements; after the counter=0 iteration go to FIXUP
  - exactly 32 CALC cycles
- FIXUP:
  - QUOTIENT = neg_q ? −Q : Q
  - REMAINDER = neg_r ? −R[31:0] : R[31:0]
  - go to FINISH
- FINISH:
  - DONE=1 for this cycle only, BUSY=0 in this cycle, next state IDLE
  - divide-by-zero path: QUOTIENT=32'hFFFFFFFF, REMAINDER=latched DIVIDEND
- BUSY=1 in CALC and FIXUP.
- Latency:
  - START sampled at edge 0 → DONE high during cycle 34 (32 CALC + FIXUP + FINISH)
  - divide-by-zero: DONE during cycle 1 after the START edge
- START while BUSY or during FINISH is ignored; no queuing. A new START is accepted in the IDLE cycle following FINISH.
- Arithmetic:
  - magnitude of 32'h80000000 is 2^31, representable unsigned
  - signed 0x80000000 / −1 yields QUOTIENT=0x80000000, REMAINDER=0 with no flag (wrap)
  - remainder sign follows dividend; |REMAINDER| < |DIVISOR|
- Input changes while BUSY have no effect on the result.

Decomposition:
- prj_definition.v additions:
  - `DATA_WIDTH, reuse `DATA_INDEX_LIMIT
  - `DIV_ST_IDLE/CALC/FIXUP/FINISH 2-bit encodings
  - `DIV_ZERO_QUOTIENT (32'hFFFFFFFF)
- One sub-module: div_trial_sub, purely combinational 33-bit subtractor returning trial value and sign bit.
- Negation uses the existing add/sub unit in subtract mode from zero, or an inline two's complement.
- FSM, counter and shift registers stay in div_seq_32.

Test Plan:
- Unsigned 100 / 7 → QUOTIENT=14, REMAINDER=2, DIV_BY_ZERO=0; DONE exactly 34 cycles after START, one cycle wide; BUSY high cycles 1–33.
- Signed −7 / 2 → QUOTIENT=32'hFFFFFFFD (−3), REMAINDER=32'hFFFFFFFF (−1); same inputs with SIGNED=0 → QUOTIENT=32'h7FFFFFFC, REMAINDER=32'h1.
- 5 / 0 (either SIGNED) → DIV_BY_ZERO=1, QUOTIENT=32'hFFFFFFFF, REMAINDER=5, DONE in cycle 1, BUSY never high.
- Signed 32'h80000000 / 32'hFFFFFFFF → QUOTIENT=32'h80000000, REMAINDER=0; unsigned 32'hFFFFFFFF / 1 → QUOTIENT=32'hFFFFFFFF, REMAINDER=0.
- Start 1000/10, then pulse START with 9/3 at cycle 5 → ignored; DONE at cycle 34 with QUOTIENT=100, REMAINDER=0.
- Start 1000/10, assert RST asynchronously mid-cycle 10 → all outputs 0 immediately, BUSY=0; after release, 9/3 → QUOTIENT=3, REMAINDER=0 in 34 cycles.
